decode_pipe: RTL

Registered, flow-controlled instruction decode stage for the Mini-MIPS pipeline, sitting between fetch and execute. It decodes one 32-bit instruction per cycle into fields plus a control bundle, and exchanges data with both neighbours through valid/ready handshakes. It adds load-use hazard interlock, pipeline flush, illegal-opcode flagging, an FP-enable mode and a saturating stall counter.

---
 rtl/decode_pipe.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// Mini-MIPS registered decode stage: field/control decode with valid/ready
// handshakes, load-use interlock, flush, illegal-opcode flagging and stall counter.
module decode_pipe #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned CNT_W     = 16,
    parameter bit          HAZARD_EN = 1'b1,
    parameter bit          FP_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm,
    output logic [25:0]       out_target,
    output logic [3:0]        out_alu_op,
    output logic [4:0]        out_dest,
    output logic [10:0]       out_ctrl,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [10:0] C_REGDST   = 11'h400;
    localparam logic [10:0] C_ALUSRC   = 11'h200;
    localparam logic [10:0] C_MEMTOREG = 11'h100;
    localparam logic [10:0] C_REGWRITE = 11'h080;
    localparam logic [10:0] C_MEMREAD  = 11'h040;
    localparam logic [10:0] C_MEMWRITE = 11'h020;
    localparam logic [10:0] C_BRANCH   = 11'h010;
    localparam logic [10:0] C_JUMP     = 11'h008;
    localparam logic [10:0] C_FPOP     = 11'h004;
    localparam logic [10:0] C_FPRW     = 11'h002;
    localparam logic [10:0] C_FPRR     = 11'h001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MFC1  = 6'h16;
    localparam logic [5:0] OP_MTC1  = 6'h17;
    localparam logic [5:0] OP_FPAR  = 6'h18;
    localparam logic [5:0] OP_FPCMP = 6'h19;
    localparam logic [5:0] OP_FPMOV = 6'h1A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_MUL   = 6'h1C;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [3:0]       w_alu;
    logic [10:0]      w_ctrl;
    logic [4:0]       w_dest;
    logic             w_legal;
    logic             w_uses_rs;
    logic             w_uses_rt;
    logic             w_hazard;
    logic             w_accept;

    logic             r_valid;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_instr;
    logic [3:0]       r_alu;
    logic [4:0]       r_dest;
    logic [10:0]      r_ctrl;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_op    = in_instr[31:26];
    assign w_rs    = in_instr[25:21];
    assign w_rt    = in_instr[20:16];
    assign w_rd    = in_instr[15:11];
    assign w_funct = in_instr[5:0];

    always_comb begin
        w_alu     = '0;
        w_ctrl    = '0;
        w_legal   = 1'b1;
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
                w_ctrl    = C_REGDST | C_REGWRITE;
                case (w_funct)
                    F_ADD:   w_alu = 4'h0;
                    F_SUB:   w_alu = 4'h1;
                    F_ADDU:  w_alu = 4'h2;
                    F_SUBU:  w_alu = 4'h3;
                    F_MULT:  begin w_alu = 4'h4; w_ctrl = '0; end
                    F_MULTU: begin w_alu = 4'h5; w_ctrl = '0; end
                    F_MUL:   w_alu = 4'h6;
                    F_AND:   w_alu = 4'h7;
                    F_OR:    w_alu = 4'h8;
                    F_NOR:   w_alu = 4'h9;
                    F_XOR:   w_alu = 4'hA;
                    F_SLL:   begin w_alu = 4'hB; w_uses_rs = 1'b0; end
                    F_SRL:   begin w_alu = 4'hC; w_uses_rs = 1'b0; end
                    F_SRA:   begin w_alu = 4'hE; w_uses_rs = 1'b0; end
                    F_SLT:   w_alu = 4'hF;
                    F_JR:    begin w_ctrl = C_JUMP; w_uses_rt = 1'b0; end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_ctrl    = C_ALUSRC | C_REGWRITE;
                w_uses_rs = 1'b1;
                case (w_op)
                    OP_ADDIU: w_alu = 4'h2;
                    OP_ANDI:  w_alu = 4'h7;
                    OP_ORI:   w_alu = 4'h8;
                    OP_XORI:  w_alu = 4'hA;
                    default:  w_alu = 4'h0;
                endcase
            end
            OP_LW: begin
                w_ctrl    = C_ALUSRC | C_MEMREAD | C_MEMTOREG | C_REGWRITE;
                w_uses_rs = 1'b1;
            end
            OP_SW: begin
                w_ctrl    = C_ALUSRC | C_MEMWRITE;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_alu     = 4'h1;
                w_ctrl    = C_BRANCH;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_J:   w_ctrl = C_JUMP;
            OP_JAL: w_ctrl = C_JUMP | C_REGWRITE;
            OP_FPAR, OP_FPMOV, OP_FPCMP, OP_MFC1, OP_MTC1: begin
                if (!FP_EN) begin
                    w_legal = 1'b0;
                end else begin
                    case (w_op)
                        OP_FPCMP: w_ctrl = C_FPOP;
                        OP_MFC1:  w_ctrl = C_FPRR | C_REGWRITE;
                        OP_MTC1:  begin w_ctrl = C_FPRW; w_uses_rt = 1'b1; end
                        default:  w_ctrl = C_FPOP | C_FPRW;
                    endcase
                end
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal instructions still flow, but must not write, read or interlock.
        if (!w_legal) begin
            w_alu     = '0;
            w_ctrl    = '0;
            w_uses_rs = 1'b0;
            w_uses_rt = 1'b0;
        end
    end

    always_comb begin
        w_dest = '0;
        if ((w_ctrl & C_REGWRITE) != '0) begin
            if (w_op == OP_JAL)
                w_dest = 5'd31;
            else if ((w_ctrl & C_REGDST) != '0)
                w_dest = w_rd;
            else
                w_dest = w_rt;
        end
    end

    assign w_hazard = HAZARD_EN && ex_memread && (ex_rt != '0) &&
                      ((w_uses_rs && (w_rs == ex_rt)) || (w_uses_rt && (w_rt == ex_rt)));
    assign in_ready = flush || (!w_hazard && (!r_valid || out_ready));
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_alu     <= '0;
            r_dest    <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_instr   <= in_instr;
                r_alu     <= w_alu;
                r_dest    <= w_dest;
                r_ctrl    <= w_ctrl;
                r_illegal <= !w_legal;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (in_valid && w_hazard && !flush && (r_cnt != '1))
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_opcode  = r_instr[31:26];
    assign out_rs      = r_instr[25:21];
    assign out_rt      = r_instr[20:16];
    assign out_rd      = r_instr[15:11];
    assign out_shamt   = r_instr[10:6];
    assign out_funct   = r_instr[5:0];
    assign out_imm     = r_instr[15:0];
    assign out_target  = r_instr[25:0];
    assign out_alu_op  = r_alu;
    assign out_dest    = r_dest;
    assign out_ctrl    = r_ctrl;
    assign out_illegal = r_illegal;
    assign stall_cnt   = r_cnt;

endmodule
